rom_state_loop_ctrl: RTL and testbench

// - Sequence-playback controller: reads a 32-bit tag-list entry from an external 2-port RAM.
// - The entry is selected by ram_counter. The controller drives a ROM address (addr) that

---
 rtl/rom_state_loop_ctrl.sv | 176 +++++++++++++++++
 tb/tb_rom_state_loop_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_state_loop_ctrl.sv
// Sequence-playback controller: sweeps a ROM address over start..end of the tag-list entry
// selected by ram_counter. Define PB_EDGE_DETECT_EN to edge-detect the push-button inputs.
module rom_state_loop_ctrl #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned IDX_W       = 7,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic              clock_p,
  input  logic              reset,
  input  logic [31:0]       data_in,
  input  logic              pb_seq_up,
  input  logic              pb_seq_dn,
  output logic              load,
  output logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  ram_counter,
  output logic              at_end_rst,
  output logic              addr_inc,
  output logic              ram_counter_inc,
  output logic              ram_counter_dec
);

  localparam int unsigned WaitW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(RAM_LATENCY - 1);

  typedef enum logic [1:0] {StFetch, StLoad, StPlay} state_e;

  state_e            state_q, state_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] start_f, end_f;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  last_idx_q, last_idx_d;
  logic              last_known_q, last_known_d;
  logic              is_last_q, is_last_d;
  logic              load_q, load_d;
  logic              at_end_q, at_end_d;
  logic              addr_inc_q, addr_inc_d;
  logic              cinc_q, cinc_d;
  logic              cdec_q, cdec_d;
  logic              up_press, dn_press, sweep_done;
  logic              unused_data;

  assign start_f     = ADDR_W'(data_in[20:11]);
  assign end_f       = ADDR_W'(data_in[10:1]);
  assign unused_data = ^data_in[31:21];

`ifdef PB_EDGE_DETECT_EN
  logic up_q1, up_q2, dn_q1, dn_q2;

  always_ff @(posedge clock_p or negedge reset) begin
    if (!reset) begin
      up_q1 <= 1'b0;
      up_q2 <= 1'b0;
      dn_q1 <= 1'b0;
      dn_q2 <= 1'b0;
    end else begin
      up_q1 <= pb_seq_up;
      up_q2 <= up_q1;
      dn_q1 <= pb_seq_dn;
      dn_q2 <= dn_q1;
    end
  end

  assign up_press = up_q1 & ~up_q2;
  assign dn_press = dn_q1 & ~dn_q2;
`else
  assign up_press = pb_seq_up;
  assign dn_press = pb_seq_dn;
`endif

  // An inverted range (end < start) ends the sweep immediately, so addr stays at start.
  assign sweep_done = (addr_q == end_f) || (end_f < start_f);

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    last_idx_d   = last_idx_q;
    last_known_d = last_known_q;
    is_last_d    = is_last_q;
    load_d       = 1'b0;
    at_end_d     = 1'b0;
    addr_inc_d   = 1'b0;
    cinc_d       = 1'b0;
    cdec_d       = 1'b0;

    if (up_press ^ dn_press) begin
      // The last flag belongs to the entry just left; a second step before LOAD counts normally.
      state_d   = StFetch;
      wait_d    = '0;
      is_last_d = 1'b0;
      if (up_press) begin
        cinc_d = 1'b1;
        cnt_d  = is_last_q ? '0 : cnt_q + IDX_W'(1);
      end else begin
        cdec_d = 1'b1;
        if (cnt_q == '0) begin
          cnt_d = last_known_q ? last_idx_q : '0;
        end else begin
          cnt_d = cnt_q - IDX_W'(1);
        end
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          if (wait_q == WaitLast) begin
            state_d = StLoad;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
        StLoad: begin
          addr_d    = start_f;
          load_d    = 1'b1;
          is_last_d = data_in[0];
          if (data_in[0]) begin
            last_idx_d   = cnt_q;
            last_known_d = 1'b1;
          end
          state_d = StPlay;
        end
        StPlay: begin
          if (sweep_done) begin
            at_end_d = 1'b1;
            state_d  = StLoad;
          end else begin
            addr_d     = addr_q + ADDR_W'(1);
            addr_inc_d = 1'b1;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clock_p or negedge reset) begin
    if (!reset) begin
      state_q      <= StFetch;
      wait_q       <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      last_idx_q   <= '0;
      last_known_q <= 1'b0;
      is_last_q    <= 1'b0;
      load_q       <= 1'b0;
      at_end_q     <= 1'b0;
      addr_inc_q   <= 1'b0;
      cinc_q       <= 1'b0;
      cdec_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      last_idx_q   <= last_idx_d;
      last_known_q <= last_known_d;
      is_last_q    <= is_last_d;
      load_q       <= load_d;
      at_end_q     <= at_end_d;
      addr_inc_q   <= addr_inc_d;
      cinc_q       <= cinc_d;
      cdec_q       <= cdec_d;
    end
  end

  assign load            = load_q;
  assign addr            = addr_q;
  assign ram_counter     = cnt_q;
  assign at_end_rst      = at_end_q;
  assign addr_inc        = addr_inc_q;
  assign ram_counter_inc = cinc_q;
  assign ram_counter_dec = cdec_q;

endmodule

// File: tb/tb_rom_state_loop_ctrl.sv
// Bench for rom_state_loop_ctrl: tag-list RAM model, per-cycle behavioural reference,
// directed literal checks and randomized push-button stimulus.
module tb_rom_state_loop_ctrl;

  localparam int unsigned AW  = 10;
  localparam int unsigned IW  = 7;
  localparam int unsigned LAT = 1;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic [31:0]   data_in = '0;
  logic          pb_up   = 1'b0;
  logic          pb_dn   = 1'b0;
  logic          load, at_end_rst, addr_inc, cinc, cdec;
  logic [AW-1:0] addr;
  logic [IW-1:0] ram_counter;

  logic [31:0] ram [128];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  rom_state_loop_ctrl #(
    .ADDR_W     (AW),
    .IDX_W      (IW),
    .RAM_LATENCY(LAT)
  ) dut (
    .clock_p        (clk),
    .reset          (rst_n),
    .data_in        (data_in),
    .pb_seq_up      (pb_up),
    .pb_seq_dn      (pb_dn),
    .load           (load),
    .addr           (addr),
    .ram_counter    (ram_counter),
    .at_end_rst     (at_end_rst),
    .addr_inc       (addr_inc),
    .ram_counter_inc(cinc),
    .ram_counter_dec(cdec)
  );

  always #5 clk = ~clk;

  // Registered-read RAM, one clock of latency.
  always @(posedge clk) begin
    data_in <= ram[ram_counter];
    cyc     <= cyc + 1;
  end

  function automatic logic [31:0] mk(input int s, input int e, input bit last);
    logic [9:0] s10, e10;
    s10 = s[9:0];
    e10 = e[9:0];
    return {4'h0, 7'h0, s10, e10, last};
  endfunction

  // Reference: phase 0 = waiting for RAM data, 1 = load next cycle, 2 = sweeping.
  int m_phase = 0, m_wait = 0, m_addr = 0, m_cnt = 0, m_last_idx = 0;
  int m_start, m_end;
  bit m_last_known = 0, m_cur_last = 0, m_up, m_dn;
  bit e_load = 0, e_end = 0, e_inc = 0, e_cinc = 0, e_cdec = 0;
  bit h_up1 = 0, h_up2 = 0, h_dn1 = 0, h_dn2 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_wait = 0; m_addr = 0; m_cnt = 0; m_last_idx = 0;
      m_last_known = 0; m_cur_last = 0;
      e_load = 0; e_end = 0; e_inc = 0; e_cinc = 0; e_cdec = 0;
      h_up1 = 0; h_up2 = 0; h_dn1 = 0; h_dn2 = 0;
    end else begin
`ifdef PB_EDGE_DETECT_EN
      m_up  = h_up1 && !h_up2;
      m_dn  = h_dn1 && !h_dn2;
      h_up2 = h_up1; h_up1 = pb_up;
      h_dn2 = h_dn1; h_dn1 = pb_dn;
`else
      m_up = pb_up;
      m_dn = pb_dn;
`endif
      e_load = 0; e_end = 0; e_inc = 0; e_cinc = 0; e_cdec = 0;
      m_start = int'(ram[m_cnt][20:11]);
      m_end   = int'(ram[m_cnt][10:1]);
      if (m_up != m_dn) begin
        if (m_up) begin
          m_cnt  = m_cur_last ? 0 : (m_cnt + 1) % 128;
          e_cinc = 1;
        end else begin
          if (m_cnt == 0) m_cnt = m_last_known ? m_last_idx : 0;
          else m_cnt = m_cnt - 1;
          e_cdec = 1;
        end
        m_cur_last = 0;
        m_phase    = 0;
        m_wait     = 0;
      end else if (m_phase == 0) begin
        m_wait++;
        if (m_wait >= LAT) begin
          m_phase = 1;
          m_wait  = 0;
        end
      end else if (m_phase == 1) begin
        m_addr     = m_start;
        e_load     = 1;
        m_cur_last = ram[m_cnt][0];
        if (ram[m_cnt][0]) begin
          m_last_idx   = m_cnt;
          m_last_known = 1;
        end
        m_phase = 2;
      end else begin
        if (m_addr == m_end || m_end < m_start) begin
          e_end   = 1;
          m_phase = 1;
        end else begin
          m_addr = m_addr + 1;
          e_inc  = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    total++;
    if (addr !== AW'(m_addr) || ram_counter !== IW'(m_cnt) || load !== e_load ||
        at_end_rst !== e_end || addr_inc !== e_inc || cinc !== e_cinc || cdec !== e_cdec) begin
      bad++;
      $display("FAIL model cyc=%0d got addr=%0d cnt=%0d ld=%b end=%b inc=%b ci=%b cd=%b want addr=%0d cnt=%0d ld=%b end=%b inc=%b ci=%b cd=%b",
               cyc, addr, ram_counter, load, at_end_rst, addr_inc, cinc, cdec,
               m_addr, m_cnt, e_load, e_end, e_inc, e_cinc, e_cdec);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic press(input bit u, input bit d);
    @(negedge clk);
    pb_up = u;
    pb_dn = d;
    @(negedge clk);
    pb_up = 1'b0;
    pb_dn = 1'b0;
`ifdef PB_EDGE_DETECT_EN
    @(negedge clk);
`endif
    #1;
  endtask

  task automatic wait_for(input bit want_end, input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      #1;
      seen = want_end ? at_end_rst : load;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s got=no pulse want=pulse within 2000 cycles", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ram[0] = mk(0, 5, 0);
    ram[1] = mk(6, 12, 0);
    ram[2] = mk(13, 21, 0);
    ram[3] = mk(22, 42, 0);
    ram[4] = mk(43, 63, 1);
    ram[5] = mk(10, 3, 0);
    for (int i = 6; i < 128; i++) begin
      ram[i] = mk($urandom_range(0, 20), $urandom_range(0, 20), i == 9);
    end

    repeat (3) @(negedge clk);
    #1;
    chk("reset_addr", 32'(addr), 0);
    chk("reset_cnt", 32'(ram_counter), 0);
    chk("reset_load", 32'(load), 0);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk); #1;
    chk("fetch_no_load", 32'(load), 0);
    @(negedge clk); #1;
    chk("first_load", 32'(load), 1);
    chk("first_addr", 32'(addr), 0);
    repeat (5) @(negedge clk);
    #1;
    chk("e0_addr5", 32'(addr), 5);
    chk("e0_no_end_yet", 32'(at_end_rst), 0);
    @(negedge clk); #1;
    chk("e0_end_pulse", 32'(at_end_rst), 1);
    @(negedge clk); #1;
    chk("e0_reload", 32'(load), 1);
    chk("e0_reload_addr", 32'(addr), 0);

    for (int k = 1; k <= 4; k++) begin
      press(1'b1, 1'b0);
      chk("up_cnt", 32'(ram_counter), 32'(k));
      chk("up_pulse", 32'(cinc), 1);
    end
    wait_for(1'b0, "e4_load");
    chk("e4_start", 32'(addr), 43);
    wait_for(1'b1, "e4_end");
    chk("e4_end_addr", 32'(addr), 63);

    press(1'b1, 1'b0);
    chk("up_wrap_cnt", 32'(ram_counter), 0);
    wait_for(1'b0, "wrap_load");
    chk("wrap_addr", 32'(addr), 0);

    press(1'b0, 1'b1);
    chk("dn_wrap_cnt", 32'(ram_counter), 4);
    chk("dn_pulse", 32'(cdec), 1);
    wait_for(1'b0, "dn_wrap_load");
    chk("dn_wrap_addr", 32'(addr), 43);
    press(1'b0, 1'b1);
    chk("dn_cnt3", 32'(ram_counter), 3);
    wait_for(1'b0, "e3_load");
    chk("e3_start", 32'(addr), 22);
    repeat (3) @(negedge clk);

    press(1'b1, 1'b1);
    chk("both_cnt", 32'(ram_counter), 3);
    chk("both_no_inc", 32'(cinc), 0);
    chk("both_no_dec", 32'(cdec), 0);
    chk("both_sweeping", 32'(addr_inc), 1);

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_addr", 32'(addr), 0);
    chk("midrst_cnt", 32'(ram_counter), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_for(1'b0, "post_rst_load");
    chk("post_rst_addr", 32'(addr), 0);
    wait_for(1'b1, "post_rst_end");
    chk("post_rst_end_addr", 32'(addr), 5);
    press(1'b0, 1'b1);
    chk("dn_at0_unknown", 32'(ram_counter), 0);
    chk("dn_at0_pulse", 32'(cdec), 1);

    for (int it = 0; it < 300; it++) begin
      int gap, kind;
      gap  = $urandom_range(0, 25);
      kind = $urandom_range(0, 9);
      repeat (gap) @(negedge clk);
      if (it == 150) begin
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      if (kind == 0) press(1'b1, 1'b1);
      else if (kind <= 4) press(1'b1, 1'b0);
      else press(1'b0, 1'b1);
    end

    repeat (30) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
